// File: rtl/mod_updown_counter.sv
`default_nettype none
// =============================================================================
// Module      : mod_updown_counter
// Description : Up/down counter with programmable modulus, parallel load,
//               wrap/saturate boundary handling, tc pulse and sticky ovf.
// Revision    : 1.0 - initial release
// =============================================================================
module mod_updown_counter #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] mod_max,
  input  logic             sat_mode,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf,
  output logic             zero
);

  localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_zero = '0;

  logic [WIDTH-1:0] r_q;
  logic             r_tc;
  logic             r_ovf;

  logic             w_at_top;
  logic             w_at_bot;
  logic             w_event;
  logic [WIDTH-1:0] w_q_next;
  logic             w_ovf_next;

  // Boundary is decided before any +/-1, so no step ever relies on carry/borrow.
  always_comb begin
    w_at_top   = (r_q >= mod_max);
    w_at_bot   = (r_q == c_zero);
    w_event    = 1'b0;
    w_q_next   = r_q;
    w_ovf_next = r_ovf & ~clr_ovf;

    if (load) begin
      w_q_next = load_val;
    end else if (en) begin
      if (up) begin
        if (w_at_top) begin
          w_event  = 1'b1;
          w_q_next = sat_mode ? mod_max : c_zero;
        end else begin
          w_q_next = r_q + c_one;
        end
      end else begin
        if (w_at_bot) begin
          w_event  = 1'b1;
          w_q_next = sat_mode ? c_zero : mod_max;
        end else begin
          w_q_next = r_q - c_one;
        end
      end
    end

    // A boundary event on the same edge as a clear wins.
    if (w_event) begin
      w_ovf_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= RST_VAL;
      r_tc  <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_q   <= w_q_next;
      r_tc  <= w_event;
      r_ovf <= w_ovf_next;
    end
  end

  assign q    = r_q;
  assign tc   = r_tc;
  assign ovf  = r_ovf;
  assign zero = (r_q == c_zero);

endmodule
`default_nettype wire

// File: tb/tb_mod_updown_counter.sv
`default_nettype none
// =============================================================================
// Module      : tb_mod_updown_counter
// Description : Scoreboard bench for mod_updown_counter; directed scenarios
//               followed by randomized traffic against an arithmetic model.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_mod_updown_counter;

  localparam int WIDTH = 8;
  localparam int RSTV  = 0;

  logic             clk = 1'b0;
  logic             rst, en, up, load, sat_mode, clr_ovf;
  logic [WIDTH-1:0] load_val, mod_max;
  logic [WIDTH-1:0] q;
  logic             tc, ovf, zero;

  typedef struct {
    int    q;
    bit    tc;
    bit    ovf;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;

  // model state
  int m_q   = 0;
  bit m_ovf = 1'b0;

  mod_updown_counter #(.WIDTH(WIDTH), .RST_VAL(RSTV[WIDTH-1:0])) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .mod_max(mod_max), .sat_mode(sat_mode), .clr_ovf(clr_ovf),
    .q(q), .tc(tc), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge and predict the post-edge state.
  task automatic step(input bit i_rst, input bit i_en, input bit i_up, input bit i_load,
                      input int i_lv, input int i_mm, input bit i_sat, input bit i_clr,
                      input string tag);
    exp_t e;
    bit   ev;
    @(negedge clk);
    rst = i_rst; en = i_en; up = i_up; load = i_load;
    load_val = i_lv[WIDTH-1:0]; mod_max = i_mm[WIDTH-1:0];
    sat_mode = i_sat; clr_ovf = i_clr;
    ev = 1'b0;
    if (i_rst) begin
      m_q = RSTV; m_ovf = 1'b0;
    end else if (i_load) begin
      m_q = i_lv;
    end else if (i_en) begin
      if (i_up) begin
        if (m_q < i_mm) m_q = m_q + 1;
        else begin ev = 1'b1; m_q = i_sat ? i_mm : 0; end
      end else begin
        if (m_q > 0) m_q = m_q - 1;
        else begin ev = 1'b1; m_q = i_sat ? 0 : i_mm; end
      end
    end
    if (!i_rst) m_ovf = ev ? 1'b1 : (m_ovf && !i_clr);
    e.q = m_q; e.tc = ev && !i_rst; e.ovf = m_ovf; e.tag = tag;
    sb.push_back(e);
  endtask

  // Monitor: the counter presents a fresh result after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.tag, ".q"},    int'(q),    e.q);
        check({e.tag, ".tc"},   int'(tc),   int'(e.tc));
        check({e.tag, ".ovf"},  int'(ovf),  int'(e.ovf));
        check({e.tag, ".zero"}, int'(zero), int'(e.q == 0));
      end
    end
  end

  initial begin
    int mm, lv;
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
    mod_max = 8'd9; sat_mode = 1'b0; clr_ovf = 1'b0;

    // reset overrides load/en
    step(1, 0, 1, 0, 0, 9, 0, 0, "rst0");
    step(0, 0, 1, 1, 5, 9, 0, 0, "ld5");
    step(1, 1, 1, 1, 77, 9, 0, 0, "rst_ovr");

    // wrap up through 9 -> 0
    for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 0, 9, 0, 0, "wrap_up");
    step(0, 0, 1, 0, 0, 9, 0, 0, "idle");

    // wrap down from 0, then saturate at 0
    step(0, 0, 0, 1, 0, 9, 0, 0, "ld0");
    step(0, 1, 0, 0, 0, 9, 0, 0, "wrap_dn");
    step(0, 0, 0, 1, 0, 9, 1, 0, "ld0s");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 9, 1, 0, "sat_dn");
    step(0, 0, 0, 1, 9, 9, 1, 0, "ld9s");
    for (int i = 0; i < 2; i++) step(0, 1, 1, 0, 0, 9, 1, 0, "sat_up");

    // load priority and out-of-range load
    step(0, 1, 1, 1, 200, 9, 0, 0, "ld200");
    step(0, 1, 1, 0, 0, 9, 0, 0, "up_oor");
    step(0, 1, 0, 1, 200, 9, 0, 0, "ld200b");
    step(0, 1, 0, 0, 0, 9, 0, 0, "dn_oor");
    step(0, 0, 0, 1, 200, 9, 1, 0, "ld200c");
    step(0, 1, 1, 0, 0, 9, 1, 0, "up_oor_sat");

    // ovf clear race
    step(0, 0, 1, 0, 0, 9, 0, 1, "clr");
    step(0, 0, 1, 1, 9, 9, 0, 0, "ld9");
    step(0, 1, 1, 0, 0, 9, 0, 1, "clr_race");
    step(0, 0, 1, 0, 0, 9, 0, 1, "clr_alone");

    // full range and mod_max = 0
    step(0, 0, 1, 1, 255, 255, 0, 0, "ldFF");
    step(0, 1, 1, 0, 0, 255, 0, 0, "ff_up");
    step(0, 1, 0, 0, 0, 255, 0, 0, "ff_dn");
    for (int i = 0; i < 3; i++) step(0, 1, i[0], 0, 0, 0, 0, 0, "mm0");

    // randomized traffic
    mm = 9;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 31) == 0) begin
        case ($urandom_range(0, 4))
          0: mm = 0;
          1: mm = 1;
          2: mm = 9;
          3: mm = 255;
          default: mm = $urandom_range(0, 255);
        endcase
      end
      lv = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
           $urandom_range(0, 15) == 0, lv, mm, $urandom_range(0, 1) != 0,
           $urandom_range(0, 7) == 0, "rand");
    end

    @(negedge clk);
    en = 1'b0; load = 1'b0; rst = 1'b0; clr_ovf = 1'b0;
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
